// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline stage register.
// Default payload widths match the 5-stage MIPS core.
package pipe_pkg;

   localparam int IR_W_DEF  = 32;
   localparam int PC_W_DEF  = 32;
   localparam int REG_W_DEF = 5;
   localparam int T_W_DEF   = 3;
   localparam int TDEC_MAX  = 8;

   typedef struct packed {
      logic [IR_W_DEF-1:0]  ir;
      logic [PC_W_DEF-1:0]  pc;
      logic [REG_W_DEF-1:0] a1;
      logic [REG_W_DEF-1:0] a2;
      logic [REG_W_DEF-1:0] a3;
      logic [T_W_DEF-1:0]   tnew;
      logic [T_W_DEF-1:0]   tuse1;
      logic [T_W_DEF-1:0]   tuse2;
   } payload_t;

   localparam payload_t PAYLOAD_ZERO = '0;

   // Saturating decrement; callers zero-extend narrower Tnew fields.
   function automatic logic [TDEC_MAX-1:0] tnew_dec(
      input logic [TDEC_MAX-1:0] t
   );
      return (t == '0) ? '0 : t - TDEC_MAX'(1);
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry holding register with valid flag.
// Clear wins over load; the payload reads zero while empty.
module pipe_skid_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_d,
   output logic         o_valid,
   output logic [W-1:0] o_q
);

   logic         r_valid;
   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_valid <= 1'b0;
         r_q     <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_q     <= i_d;
      end
   end

   assign o_valid = r_valid;
   assign o_q     = r_q;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready, flush and Tnew countdown.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid slot (capacity 2).
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int IR_W     = IR_W_DEF,
   parameter int PC_W     = PC_W_DEF,
   parameter int REG_W    = REG_W_DEF,
   parameter int T_W      = T_W_DEF,
   parameter int DEC_TNEW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IR_W-1:0]  in_ir,
   input  logic [PC_W-1:0]  in_pc,
   input  logic [REG_W-1:0] in_a1,
   input  logic [REG_W-1:0] in_a2,
   input  logic [REG_W-1:0] in_a3,
   input  logic [T_W-1:0]   in_tnew,
   input  logic [T_W-1:0]   in_tuse1,
   input  logic [T_W-1:0]   in_tuse2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IR_W-1:0]  out_ir,
   output logic [PC_W-1:0]  out_pc,
   output logic [REG_W-1:0] out_a1,
   output logic [REG_W-1:0] out_a2,
   output logic [REG_W-1:0] out_a3,
   output logic [T_W-1:0]   out_tnew,
   output logic [T_W-1:0]   out_tuse1,
   output logic [T_W-1:0]   out_tuse2
);

   typedef struct packed {
      logic [IR_W-1:0]  ir;
      logic [PC_W-1:0]  pc;
      logic [REG_W-1:0] a1;
      logic [REG_W-1:0] a2;
      logic [REG_W-1:0] a3;
      logic [T_W-1:0]   tnew;
      logic [T_W-1:0]   tuse1;
      logic [T_W-1:0]   tuse2;
   } pl_t;

   localparam int PL_W = $bits(pl_t);

   pl_t            r_main;
   logic           r_valid;
   pl_t            w_in_pl;
   pl_t            w_main_d;
   logic           w_main_ld;
   logic           w_in_xfer;
   logic           w_out_xfer;
   logic [T_W-1:0] w_tnew;

   assign w_tnew = (DEC_TNEW != 0)
                 ? T_W'(tnew_dec(TDEC_MAX'(in_tnew)))
                 : in_tnew;

   assign w_in_pl = '{in_ir, in_pc, in_a1, in_a2, in_a3,
                      w_tnew, in_tuse1, in_tuse2};

   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic            w_skid_valid;
   logic            w_skid_load;
   logic            w_skid_clr;
   logic [PL_W-1:0] w_skid_raw;

   // Skid only catches input arriving while main is full and stalled.
   assign w_skid_load = w_in_xfer && r_valid && !out_ready;
   assign w_skid_clr  = flush || w_out_xfer;
   assign in_ready    = !w_skid_valid;

   pipe_skid_slot #(.W(PL_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_skid_clr),
      .i_load  (w_skid_load),
      .i_d     (w_in_pl),
      .o_valid (w_skid_valid),
      .o_q     (w_skid_raw)
   );

   assign w_main_ld = (w_out_xfer && w_skid_valid)
                   || (w_in_xfer && (out_ready || !r_valid));
   assign w_main_d  = w_skid_valid ? pl_t'(w_skid_raw) : w_in_pl;
`else
   assign in_ready  = out_ready || !r_valid;
   assign w_main_ld = w_in_xfer;
   assign w_main_d  = w_in_pl;
`endif

   // Payload is cleared whenever the entry empties so a bubble has a3=0.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid <= 1'b0;
         r_main  <= '0;
      end else if (w_main_ld) begin
         r_valid <= 1'b1;
         r_main  <= w_main_d;
      end else if (w_out_xfer) begin
         r_valid <= 1'b0;
         r_main  <= '0;
      end
   end

   assign out_valid = r_valid;
   assign out_ir    = r_main.ir;
   assign out_pc    = r_main.pc;
   assign out_a1    = r_main.a1;
   assign out_a2    = r_main.a2;
   assign out_a3    = r_main.a3;
   assign out_tnew  = r_main.tnew;
   assign out_tuse1 = r_main.tuse1;
   assign out_tuse2 = r_main.tuse2;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage (DEC_TNEW=1 and DEC_TNEW=0 instances).
// Skid expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage;
   import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_ir, in_pc;
   logic [4:0]  in_a1, in_a2, in_a3;
   logic [2:0]  in_tnew, in_tuse1, in_tuse2;

   logic        in_ready, out_valid;
   logic [31:0] out_ir, out_pc;
   logic [4:0]  out_a1, out_a2, out_a3;
   logic [2:0]  out_tnew, out_tuse1, out_tuse2;

   logic        nd_in_ready, nd_out_valid;
   logic [31:0] nd_out_ir, nd_out_pc;
   logic [4:0]  nd_out_a1, nd_out_a2, nd_out_a3;
   logic [2:0]  nd_out_tnew, nd_out_tuse1, nd_out_tuse2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage #(.DEC_TNEW(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ir(in_ir), .in_pc(in_pc),
      .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
      .in_tnew(in_tnew), .in_tuse1(in_tuse1), .in_tuse2(in_tuse2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ir(out_ir), .out_pc(out_pc),
      .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3),
      .out_tnew(out_tnew), .out_tuse1(out_tuse1),
      .out_tuse2(out_tuse2)
   );

   pipe_stage #(.DEC_TNEW(0)) u_nodec (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(nd_in_ready),
      .in_ir(in_ir), .in_pc(in_pc),
      .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
      .in_tnew(in_tnew), .in_tuse1(in_tuse1), .in_tuse2(in_tuse2),
      .out_valid(nd_out_valid), .out_ready(out_ready),
      .out_ir(nd_out_ir), .out_pc(nd_out_pc),
      .out_a1(nd_out_a1), .out_a2(nd_out_a2), .out_a3(nd_out_a3),
      .out_tnew(nd_out_tnew), .out_tuse1(nd_out_tuse1),
      .out_tuse2(nd_out_tuse2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic [4:0] a3, input logic [2:0] tn);
      in_valid = v;
      in_pc    = pc;
      in_ir    = 32'h2000_0000 | pc;
      in_a1    = 5'd1;
      in_a2    = 5'd2;
      in_a3    = a3;
      in_tnew  = tn;
   endtask

   task automatic test_reset();
      payload_t got;
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h0, 5'd3, 3'd2);
      in_ir = 32'h2409_0005;
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      got = {out_ir, out_pc, out_a1, out_a2, out_a3,
             out_tnew, out_tuse1, out_tuse2};
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b exp 0", out_valid);
      end
      checks++;
      if (got !== PAYLOAD_ZERO) begin
         errors++;
         $display("FAIL reset_payload: got %h exp 0", got);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b exp 1", in_ready);
      end
      checks++;
      if (nd_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_nd_valid: got %b exp 0", nd_out_valid);
      end
   endtask

   task automatic test_stream();
      logic [31:0] pc;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pc = 32'h3000 + 32'(4 * i);
         drive(1'b1, pc, 5'(i + 1), 3'd2);
         tick();
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_valid[%0d]: got %b exp 1", i, out_valid);
         end
         checks++;
         if (out_pc !== pc) begin
            errors++;
            $display("FAIL stream_pc[%0d]: got %h exp %h", i, out_pc, pc);
         end
         checks++;
         if (out_tnew !== 3'd1) begin
            errors++;
            $display("FAIL stream_tnew[%0d]: got %0d exp 1", i, out_tnew);
         end
         checks++;
         if (out_a3 !== 5'(i + 1)) begin
            errors++;
            $display("FAIL stream_a3[%0d]: got %0d exp %0d",
                     i, out_a3, i + 1);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL stream_drain: got v=%b pc=%h exp v=0 pc=0",
                  out_valid, out_pc);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      drive(1'b1, 32'h3004, 5'd4, 3'd2);
      tick();
      drive(1'b1, 32'h3008, 5'd5, 3'd2);
      #1;
      checks++;
      if (in_ready !== SKID) begin
         errors++;
         $display("FAIL stall_ready0: got %b exp %b", in_ready, SKID);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (SKID && c == 0) in_valid = 1'b0;
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'h3004 ||
             out_a3 !== 5'd4 || out_ir !== 32'h2000_3004) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b pc=%h a3=%0d ir=%h exp v=1 pc=3004 a3=4 ir=20003004",
                     c, out_valid, out_pc, out_a3, out_ir);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready[%0d]: got %b exp 0", c, in_ready);
         end
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3008 || out_a3 !== 5'd5) begin
         errors++;
         $display("FAIL stall_release: got v=%b pc=%h a3=%0d exp v=1 pc=3008 a3=5",
                  out_valid, out_pc, out_a3);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_empty: got %b exp 0", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'h4000, 5'd7, 3'd3);
      tick();
      if (SKID) begin
         drive(1'b1, 32'h4004, 5'd8, 3'd3);
         tick();
      end
      flush = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h4008, 5'd9, 3'd3);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_a3 !== 5'd0 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL flush_clear: got v=%b a3=%0d pc=%h exp v=0 a3=0 pc=0",
                  out_valid, out_a3, out_pc);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: got %b exp 1", in_ready);
      end
      checks++;
      if (nd_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_nd_valid: got %b exp 0", nd_out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_dropped: got v=%b pc=%h exp v=0",
                  out_valid, out_pc);
      end
      drive(1'b1, 32'h400C, 5'd10, 3'd3);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h400C || out_a3 !== 5'd10) begin
         errors++;
         $display("FAIL flush_next: got v=%b pc=%h a3=%0d exp v=1 pc=400c a3=10",
                  out_valid, out_pc, out_a3);
      end
      tick();
   endtask

   task automatic test_saturation();
      out_ready = 1'b1;
      drive(1'b1, 32'h5000, 5'd3, 3'd0);
      in_tuse1 = 3'd3;
      in_tuse2 = 3'd6;
      tick();
      checks++;
      if (out_tnew !== 3'd0) begin
         errors++;
         $display("FAIL sat_tnew0: got %0d exp 0", out_tnew);
      end
      checks++;
      if (out_tuse1 !== 3'd3 || out_tuse2 !== 3'd6) begin
         errors++;
         $display("FAIL sat_tuse: got %0d/%0d exp 3/6",
                  out_tuse1, out_tuse2);
      end
      drive(1'b1, 32'h5004, 5'd3, 3'd7);
      tick();
      checks++;
      if (out_tnew !== 3'd6) begin
         errors++;
         $display("FAIL sat_tnew7: got %0d exp 6", out_tnew);
      end
      checks++;
      if (nd_out_tnew !== 3'd7) begin
         errors++;
         $display("FAIL sat_nd_tnew7: got %0d exp 7", nd_out_tnew);
      end
      drive(1'b1, 32'h5008, 5'd3, 3'd5);
      tick();
      checks++;
      if (out_tnew !== 3'd4) begin
         errors++;
         $display("FAIL sat_tnew5: got %0d exp 4", out_tnew);
      end
      checks++;
      if (nd_out_tnew !== 3'd5) begin
         errors++;
         $display("FAIL sat_nd_tnew5: got %0d exp 5", nd_out_tnew);
      end
      in_valid = 1'b0;
      in_tuse1 = 3'd0;
      in_tuse2 = 3'd0;
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive(1'b1, 32'h300C, 5'd6, 3'd2);
      tick();
      drive(1'b1, 32'h3010, 5'd7, 3'd2);
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL simul_ready: got %b exp 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3010) begin
         errors++;
         $display("FAIL simul_replace: got v=%b pc=%h exp v=1 pc=3010",
                  out_valid, out_pc);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_empty: got %b exp 0", out_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b1;
      in_tuse1 = 3'd0;
      in_tuse2 = 3'd0;
      drive(1'b0, 32'h0, 5'd0, 3'd0);
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_saturation();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register for the 5-stage MIPS core. It replaces the per-stage hand-written D/E/M/W registers with one block. The block carries the instruction word, PC, register addresses and hazard timing fields (Tnew, Tuse1, Tuse2) under a valid/ready handshake, with flush and automatic Tnew countdown. One instance sits between each pair of adjacent stages; the hazard unit reads its outputs for stall and forward decisions.

## Interface
Parameters:
- IR_W, 32, instruction word width
- PC_W, 32, program counter width
- REG_W, 5, register address width
- T_W, 3, width of Tnew/Tuse fields
- DEC_TNEW, 1, 1 = Tnew decremented (saturating) on entry to this stage; 0 = pass-through

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard every held entry; has priority over everything except rst
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts input this cycle
- in_ir, in_pc, in_a1, in_a2, in_a3  in  IR_W/PC_W/REG_W  payload
- in_tnew, in_tuse1, in_tuse2  in  T_W  hazard timing
- out_valid  out  1  stage holds a valid instruction
- out_ready  in  1  downstream accepts this cycle
- out_ir, out_pc, out_a1, out_a2, out_a3, out_tnew, out_tuse1, out_tuse2  out  matching widths  held payload

## Operation
- Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready at posedge.
- Stored Tnew with DEC_TNEW=1: in_tnew==0 ? 0 : in_tnew-1, in T_W bits with no wrap. Tuse fields are stored unmodified.
- Bubble rule: whenever out_valid=0, every out_* payload field is 0. This guarantees out_a3=0, so an empty stage never matches in forwarding.
- Main entry: if out_ready, or if the entry is empty, load the input on an in-transfer; otherwise hold.
- Simultaneous in-transfer and out-transfer: the new entry replaces the old one; out_valid stays 1.
- Flush: the next cycle has out_valid=0 and all held entries cleared. Input presented in the flush cycle is dropped, even if in_ready=1.
- rst overrides flush and all handshakes.

## Timing
- Reset values: out_valid=0, all out_* fields=0, internal skid entry empty. in_ready=1 in the cycle after reset.
- Latency: 1 cycle from in-transfer to out_valid. Sustained throughput: 1 instruction/cycle.
- No valid entry is lost or duplicated under any combination of in_valid, out_ready and flush.
- Stall: out_ready=0 with a full stage holds every output stable, bit-exact, across cycles.
- Flush and rst issued mid-stall both empty the stage in one cycle.

## Configuration
- PIPE_STAGE_SKID_EN undefined:
  - in_ready = out_ready || !out_valid, combinational.
  - Capacity is 1 entry.
- PIPE_STAGE_SKID_EN defined:
  - Adds a 1-entry skid slot. in_ready = !skid_valid, driven from a flop.
  - If an in-transfer occurs while the main entry is full and out_ready=0, the input goes into the skid slot.
  - On the next out-transfer, main loads from the skid slot and the skid slot empties.
  - Order is preserved. Capacity is 2 entries.
  - Flush clears both entries.

## Structure
- Package pipe_pkg holds:
  - the constants REG_W_DEF=5 and T_W_DEF=3;
  - a tnew_dec function (saturating decrement);
  - a packed payload struct type;
  - a zero-payload constant used for bubbles.
- Sub-module pipe_skid_slot (a payload register plus valid flag, with load/clear) is instantiated only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_ir=0x2409_0005. Required: out_valid=0, all outputs 0 after reset, in_ready=1.
- Streaming: out_ready=1, 4 back-to-back inputs with PC 0x3000/0x3004/0x3008/0x300C and in_tnew=2. Required: same PCs in order on out_pc one cycle later, out_tnew=1 (DEC_TNEW=1), no gaps.
- Stall: out_ready=0 for 3 cycles while holding PC 0x3004. Required: outputs frozen. Without skid, in_ready=0; with skid, one extra entry (PC 0x3008) is accepted, then in_ready=0. On release, 0x3004 then 0x3008 drain in order.
- Flush: assert flush with both entries full and in_valid=1. Required: out_valid=0 and out_a3=0 next cycle; the input is dropped; the next input after flush appears normally.
- Saturation: in_tnew=0 with DEC_TNEW=1 gives out_tnew=0. in_tnew=7 gives 6. With DEC_TNEW=0, in_tnew=5 gives 5.
- Simultaneous: full stage, out_ready=1, in_valid=1 with PC 0x3010. Required: PC 0x3010 is on out_pc next cycle; out_valid stays 1.
